// File: rtl/rgmii_delay_pkg.sv
// Shared types and lane constants for the RGMII delay tap controller.
// No logic; pure declarations.
// Imported by the tuner top and the EN_VTC/LOAD sequencer.
package rgmii_delay_pkg;

  typedef enum logic [2:0] {
    WAIT_RDY, IDLE, PRE, LOAD, POST, DWELL, EVAL, FINISH
  } state_t;

  // What the current load sequence belongs to, so POST knows where to go next.
  typedef enum logic [1:0] {
    OP_MANUAL, OP_STEP, OP_FINAL
  } op_t;

  // Internal phase of the EN_VTC/LOAD sequencer.
  typedef enum logic [1:0] {
    PH_IDLE, PH_PRE, PH_LOAD, PH_POST
  } phase_t;

  localparam int LANE_RXD0  = 0;
  localparam int LANE_RXD1  = 1;
  localparam int LANE_RXD2  = 2;
  localparam int LANE_RXD3  = 3;
  localparam int LANE_RXCTL = 4;
  localparam int LANE_TXCLK = 5;

  // RX data and control lanes; the TX clock odelay is never swept.
  localparam logic [5:0] RX_LANE_MASK = 6'b01_1111;

endpackage

// File: rtl/rgmii_delay_loader.sv
// EN_VTC guard / LOAD strobe sequencer for a masked set of delay lanes.
// Latency: start -> VTC_GUARD cycles EN_VTC low, 1-cycle LOAD, VTC_GUARD cycles low, done.
// No backpressure: start is only honoured when idle; abort drops back to idle at once.
module rgmii_delay_loader
  import rgmii_delay_pkg::*;
#(
  parameter int NUM_LANES = 6,
  parameter int VTC_GUARD = 8
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] mask,
  output logic [NUM_LANES-1:0] en_vtc,
  output logic [NUM_LANES-1:0] tap_load,
  output logic                 pre_done,
  output logic                 done
);

  localparam int CNT_W = $clog2(VTC_GUARD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VTC_GUARD - 1);

  phase_t               phase;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_LANES-1:0] mask_q;

  assign pre_done = (phase == PH_PRE)  && (cnt == LAST);
  assign done     = (phase == PH_POST) && (cnt == LAST);
  assign en_vtc   = (phase == PH_IDLE) ? '1 : ~mask_q;
  assign tap_load = (phase == PH_LOAD) ? mask_q : '0;

  // Phase/counter walk: PRE guard, single LOAD cycle, POST guard.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase  <= PH_IDLE;
      cnt    <= '0;
      mask_q <= '0;
    end else if (abort) begin
      phase <= PH_IDLE;
    end else begin
      case (phase)
        PH_IDLE: if (start) begin
          phase  <= PH_PRE;
          cnt    <= '0;
          mask_q <= mask;
        end
        PH_PRE: begin
          if (pre_done) phase <= PH_LOAD;
          else          cnt   <= cnt + CNT_W'(1);
        end
        PH_LOAD: begin
          phase <= PH_POST;
          cnt   <= '0;
        end
        PH_POST: begin
          if (done) phase <= PH_IDLE;
          else      cnt   <= cnt + CNT_W'(1);
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rgmii_delay_tuner.sv
// Runtime RGMII delay tap controller: manual per-lane writes plus a frame-scored RX tap sweep.
// Latency: each tap load costs 2*VTC_GUARD+1 cycles; a sweep step adds the dwell on MAC frames.
// Backpressure: cfg_ready is high only in IDLE; cal_start outside IDLE is ignored. Option: RGMII_DELAY_MAP_EN adds cal_map.
module rgmii_delay_tuner
  import rgmii_delay_pkg::*;
#(
  parameter int NUM_LANES      = 6,
  parameter int TAP_WIDTH      = 9,
  parameter int DEFAULT_TAP    = 25,
  parameter int TAP_STEP       = 8,
  parameter int DWELL_FRAMES   = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int VTC_GUARD      = 8
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           dly_rdy,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [$clog2(NUM_LANES)-1:0]   cfg_lane,
  input  logic [TAP_WIDTH-1:0]           cfg_tap,
  input  logic                           cal_start,
  input  logic                           frame_good,
  input  logic                           frame_bad,
  output logic [NUM_LANES*TAP_WIDTH-1:0] tap_value,
  output logic [NUM_LANES-1:0]           tap_load,
  output logic [NUM_LANES-1:0]           en_vtc,
  output logic                           cal_busy,
  output logic                           cal_done,
  output logic                           cal_fail,
  output logic [TAP_WIDTH-1:0]           cal_tap
`ifdef RGMII_DELAY_MAP_EN
  ,
  output logic [(2**TAP_WIDTH)/TAP_STEP-1:0] cal_map
`endif
);

  localparam int NUM_STEPS = (2**TAP_WIDTH) / TAP_STEP;
  localparam int STEP_W    = $clog2(NUM_STEPS);
  localparam int FRM_W     = $clog2(DWELL_FRAMES + 1);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_LANES-1:0] RX_MASK = NUM_LANES'(RX_LANE_MASK);

  logic [1:0]                          rdy_sync;
  logic                                rdy;
  state_t                              state, state_n;
  op_t                                 op;
  logic [NUM_LANES-1:0][TAP_WIDTH-1:0] taps;
  logic                                ld_start, ld_pre_done, ld_done;
  logic [NUM_LANES-1:0]                ld_mask;
  logic                                cfg_hit, frame_any, dwell_end, dwell_pass;
  logic [STEP_W-1:0]                   step, run_start, run_start_eff, best_start, best_end;
  logic [STEP_W:0]                     best_len, run_len;
  logic                                in_run, step_pass;
  logic [FRM_W-1:0]                    frm_cnt;
  logic [TMO_W-1:0]                    tmo_cnt;
  logic [TAP_WIDTH-1:0]                next_step_tap, best_start_tap, best_end_tap, centre_tap;
  logic [TAP_WIDTH:0]                  centre_sum;

  assign rdy       = rdy_sync[1];
  assign tap_value = taps;
  assign cfg_hit   = int'(cfg_lane) < NUM_LANES;
  assign frame_any = frame_good | frame_bad;

  // A passing step either extends the open run or opens a new one at this step.
  assign run_start_eff  = in_run ? run_start : step;
  assign run_len        = {1'b0, step} - {1'b0, run_start_eff} + (STEP_W+1)'(1);
  assign next_step_tap  = TAP_WIDTH'((int'(step) + 1) * TAP_STEP);
  assign best_start_tap = TAP_WIDTH'(int'(best_start) * TAP_STEP);
  assign best_end_tap   = TAP_WIDTH'(int'(best_end) * TAP_STEP);
  // One extra bit so the sum of two high taps cannot wrap before halving.
  assign centre_sum     = {1'b0, best_start_tap} + {1'b0, best_end_tap};
  assign centre_tap     = centre_sum[TAP_WIDTH:1];

  rgmii_delay_loader #(
    .NUM_LANES (NUM_LANES),
    .VTC_GUARD (VTC_GUARD)
  ) u_loader (
    .clock    (clock),
    .resetn   (resetn),
    .start    (ld_start),
    .abort    (!rdy),
    .mask     (ld_mask),
    .en_vtc   (en_vtc),
    .tap_load (tap_load),
    .pre_done (ld_pre_done),
    .done     (ld_done)
  );

  // Next state, loader kick-off and dwell verdict.
  always_comb begin
    state_n    = state;
    ld_start   = 1'b0;
    ld_mask    = '0;
    cfg_ready  = 1'b0;
    dwell_end  = 1'b0;
    dwell_pass = 1'b0;
    if (!rdy) begin
      state_n = WAIT_RDY;
    end else begin
      case (state)
        WAIT_RDY: state_n = IDLE;
        IDLE: begin
          cfg_ready = !cal_start;
          if (cal_start) begin
            state_n  = PRE;
            ld_start = 1'b1;
            ld_mask  = RX_MASK;
          end else if (cfg_valid && cfg_hit) begin
            state_n  = PRE;
            ld_start = 1'b1;
            ld_mask  = NUM_LANES'(1) << cfg_lane;
          end
        end
        PRE:  if (ld_pre_done) state_n = LOAD;
        LOAD: state_n = POST;
        POST: if (ld_done) state_n = (op == OP_STEP) ? DWELL : IDLE;
        DWELL: begin
          if (frame_bad) begin
            dwell_end = 1'b1;
          end else if (frame_good) begin
            if (frm_cnt == FRM_W'(DWELL_FRAMES - 1)) begin
              dwell_end  = 1'b1;
              dwell_pass = 1'b1;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            dwell_end = 1'b1;
          end
          if (dwell_end) state_n = EVAL;
        end
        EVAL: begin
          state_n = (step == STEP_W'(NUM_STEPS - 1)) ? FINISH : PRE;
          if (step != STEP_W'(NUM_STEPS - 1)) begin
            ld_start = 1'b1;
            ld_mask  = RX_MASK;
          end
        end
        FINISH: begin
          state_n  = PRE;
          ld_start = 1'b1;
          ld_mask  = RX_MASK;
        end
        default: state_n = WAIT_RDY;
      endcase
    end
  end

  // RDY synchroniser and state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdy_sync <= '0;
      state    <= WAIT_RDY;
    end else begin
      rdy_sync <= {rdy_sync[0], dly_rdy};
      state    <= state_n;
    end
  end

  // Tap registers, sweep bookkeeping and calibration status.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LANES; i++) taps[i] <= TAP_WIDTH'(DEFAULT_TAP);
      op         <= OP_MANUAL;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_fail   <= 1'b0;
      cal_tap    <= TAP_WIDTH'(DEFAULT_TAP);
      step       <= '0;
      run_start  <= '0;
      best_start <= '0;
      best_end   <= '0;
      best_len   <= '0;
      in_run     <= 1'b0;
      step_pass  <= 1'b0;
      frm_cnt    <= '0;
      tmo_cnt    <= '0;
    end else if (!rdy) begin
      cal_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cal_start) begin
            op       <= OP_STEP;
            cal_busy <= 1'b1;
            cal_done <= 1'b0;
            cal_fail <= 1'b0;
            step     <= '0;
            in_run   <= 1'b0;
            best_len <= '0;
            for (int i = 0; i < NUM_LANES; i++) if (RX_MASK[i]) taps[i] <= '0;
          end else if (cfg_valid && cfg_hit) begin
            op             <= OP_MANUAL;
            taps[cfg_lane] <= cfg_tap;
          end
        end
        POST: if (ld_done) begin
          frm_cnt <= '0;
          tmo_cnt <= '0;
          if (op == OP_FINAL) begin
            cal_busy <= 1'b0;
            if (best_len != '0) cal_done <= 1'b1;
            else                cal_fail <= 1'b1;
          end
        end
        DWELL: begin
          if (frame_any) begin
            frm_cnt <= frm_cnt + FRM_W'(1);
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
          if (dwell_end) step_pass <= dwell_pass;
        end
        EVAL: begin
          if (step_pass) begin
            in_run    <= 1'b1;
            run_start <= run_start_eff;
            if (run_len > best_len) begin
              best_start <= run_start_eff;
              best_end   <= step;
              best_len   <= run_len;
            end
          end else begin
            in_run <= 1'b0;
          end
          if (step != STEP_W'(NUM_STEPS - 1)) begin
            step <= step + STEP_W'(1);
            for (int i = 0; i < NUM_LANES; i++) if (RX_MASK[i]) taps[i] <= next_step_tap;
          end
        end
        FINISH: begin
          op <= OP_FINAL;
          if (best_len != '0) begin
            cal_tap <= centre_tap;
            for (int i = 0; i < NUM_LANES; i++) if (RX_MASK[i]) taps[i] <= centre_tap;
          end else begin
            cal_tap <= TAP_WIDTH'(DEFAULT_TAP);
            for (int i = 0; i < NUM_LANES; i++) if (RX_MASK[i]) taps[i] <= TAP_WIDTH'(DEFAULT_TAP);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RGMII_DELAY_MAP_EN
  // Per-step pass map, cleared at the start of every sweep.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cal_map <= '0;
    end else if (rdy && state == IDLE && cal_start) begin
      cal_map <= '0;
    end else if (rdy && state == EVAL) begin
      cal_map[step] <= step_pass;
    end
  end
`endif

endmodule

// File: tb/tb_rgmii_delay_tuner.sv
// Self-checking bench for rgmii_delay_tuner: manual-write table, calibration table, random sweeps.
// A channel model turns the lane-0 tap into good/bad/both/silent MAC frame pulses.
// Expected sweep results come from an exhaustive window search over the channel table.
module tb_rgmii_delay_tuner;

  localparam int NL = 6, TW = 9, DEF = 25, STEP = 8, NSTEPS = 64, TMO = 100, G = 8;
  localparam int C_GOOD = 0, C_BAD = 1, C_BOTH = 2, C_SILENT = 3;

  logic clock = 1'b0, resetn = 1'b1, dly_rdy = 1'b0;
  logic cfg_valid = 1'b0, cal_start = 1'b0, frame_good = 1'b0, frame_bad = 1'b0;
  logic [2:0] cfg_lane = '0;
  logic [TW-1:0] cfg_tap = '0;
  logic cfg_ready, cal_busy, cal_done, cal_fail;
  logic [NL*TW-1:0] tap_value;
  logic [NL-1:0] tap_load, en_vtc;
  logic [TW-1:0] cal_tap;
`ifdef RGMII_DELAY_MAP_EN
  logic [NSTEPS-1:0] cal_map;
`endif

  always #4 clock = ~clock;

  rgmii_delay_tuner #(
    .NUM_LANES(NL), .TAP_WIDTH(TW), .DEFAULT_TAP(DEF), .TAP_STEP(STEP),
    .DWELL_FRAMES(8), .TIMEOUT_CYCLES(TMO), .VTC_GUARD(G)
  ) dut (
    .clock(clock), .resetn(resetn), .dly_rdy(dly_rdy),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_lane(cfg_lane), .cfg_tap(cfg_tap),
    .cal_start(cal_start), .frame_good(frame_good), .frame_bad(frame_bad),
    .tap_value(tap_value), .tap_load(tap_load), .en_vtc(en_vtc),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail), .cal_tap(cal_tap)
`ifdef RGMII_DELAY_MAP_EN
    , .cal_map(cal_map)
`endif
  );

  int checks = 0, passes = 0;
  int mdl[NL];
  int chan[NSTEPS];
  bit chan_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int lane_tap(input int l);
    return int'(tap_value[l*TW +: TW]);
  endfunction

  // Channel model: frame type depends on the step the lane-0 tap falls in.
  initial begin : frame_gen
    int gap, k;
    gap = 0;
    forever begin
      @(negedge clock);
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      if (chan_en && gap == 0) begin
        k = lane_tap(0) / STEP;
        case (chan[k])
          C_GOOD: frame_good = 1'b1;
          C_BAD:  frame_bad  = 1'b1;
          C_BOTH: begin frame_good = 1'b1; frame_bad = 1'b1; end
          default: ;
        endcase
        gap = $urandom_range(0, 3);
      end else if (gap > 0) begin
        gap--;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Reference: longest all-good step run, earliest on ties, centre of its tap range.
  task automatic ref_cal(output int tap, output bit done);
    int best_len, bs, be;
    bit all;
    best_len = 0; bs = 0; be = 0;
    for (int s = 0; s < NSTEPS; s++)
      for (int e = s; e < NSTEPS; e++) begin
        all = 1'b1;
        for (int j = s; j <= e; j++) if (chan[j] != C_GOOD) all = 1'b0;
        if (all && (e - s + 1) > best_len) begin best_len = e - s + 1; bs = s; be = e; end
      end
    done = best_len > 0;
    tap  = done ? (bs * STEP + be * STEP) / 2 : DEF;
  endtask

  task automatic fill_windows(input int lo1, hi1, lo2, hi2, input bit silent);
    int t;
    for (int k = 0; k < NSTEPS; k++) begin
      t = k * STEP;
      if ((t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2)) chan[k] = C_GOOD;
      else chan[k] = silent ? C_SILENT : C_BAD;
    end
  endtask

  task automatic random_chan();
    int r, s, len;
    for (int k = 0; k < NSTEPS; k++) begin
      r = $urandom_range(0, 15);
      chan[k] = (r == 0) ? C_SILENT : (r < 3) ? C_BOTH : C_BAD;
    end
    repeat ($urandom_range(1, 3)) begin
      s = $urandom_range(0, NSTEPS - 1);
      len = $urandom_range(1, 20);
      for (int j = s; j < s + len && j < NSTEPS; j++) chan[j] = C_GOOD;
    end
    if ($urandom_range(0, 1) == 1) chan[$urandom_range(0, NSTEPS - 1)] = C_BOTH;
  endtask

  task automatic wait_ready(output bit ok, input int bound);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (cfg_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    for (int l = 0; l < NL; l++) check($sformatf("%s_tap%0d", pfx, l), lane_tap(l), DEF);
    check({pfx, "_en_vtc"}, en_vtc, 6'h3f);
    check({pfx, "_tap_load"}, tap_load, 0);
    check({pfx, "_flags"}, {cal_busy, cal_done, cal_fail}, 0);
    check({pfx, "_cal_tap"}, cal_tap, DEF);
  endtask

  task automatic check_taps(input string pfx);
    for (int l = 0; l < NL; l++) check($sformatf("%s_tap%0d", pfx, l), lane_tap(l), mdl[l]);
  endtask

  task automatic manual_write(input string nm, input int lane, input int tap,
                              input int exp_lows, input int exp_loads);
    int lows, loads, first_low, load_idx, load_val, other;
    bit ok;
    lows = 0; loads = 0; first_low = -1; load_idx = -1; load_val = -1; other = 0;
    wait_ready(ok, 50);
    check({nm, "_ready"}, ok, 1);
    cfg_lane = 3'(lane); cfg_tap = TW'(tap); cfg_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      cfg_valid = 1'b0;
      for (int l = 0; l < NL; l++) begin
        if (l == lane) begin
          if (!en_vtc[l]) begin lows++; if (first_low < 0) first_low = i; end
          if (tap_load[l]) begin loads++; load_idx = i; load_val = lane_tap(l); end
        end else if (!en_vtc[l] || tap_load[l]) other++;
      end
    end
    if (lane < NL) mdl[lane] = tap;
    check({nm, "_vtc_low_cycles"}, lows, exp_lows);
    check({nm, "_load_pulses"}, loads, exp_loads);
    check({nm, "_other_lanes_quiet"}, other, 0);
    if (exp_loads > 0) begin
      check({nm, "_first_low"}, first_low, 0);
      check({nm, "_load_pos"}, load_idx, G);
      check({nm, "_load_val"}, load_val, tap);
    end
    check_taps(nm);
  endtask

  task automatic run_cal(input string nm, input int exp_tap, input bit exp_done, input bit inject);
    bit ok;
    wait_ready(ok, 50);
    check({nm, "_idle"}, ok, 1);
    chan_en = 1'b1; cal_start = 1'b1;
    @(negedge clock);
    cal_start = 1'b0;
    check({nm, "_busy"}, cal_busy, 1);
    check({nm, "_flags_clr"}, {cal_done, cal_fail}, 0);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clock);
      cal_start = inject && (c == 300);
      if (!cal_busy) begin ok = 1'b1; break; end
    end
    cal_start = 1'b0; chan_en = 1'b0;
    check({nm, "_finished"}, ok, 1);
    check({nm, "_done"}, cal_done, exp_done);
    check({nm, "_fail"}, cal_fail, !exp_done);
    check({nm, "_cal_tap"}, cal_tap, exp_tap);
    for (int l = 0; l < 5; l++) mdl[l] = exp_tap;
    check_taps(nm);
    check({nm, "_en_vtc"}, en_vtc, 6'h3f);
  endtask

  typedef struct {
    string nm; int lane; int tap; int exp_lows; int exp_loads;
  } wr_vec_t;

  typedef struct {
    string nm; int lo1; int hi1; int lo2; int hi2; bit silent;
    int exp_tap; bit exp_done; bit inject;
  } cal_vec_t;

  initial begin : main
    wr_vec_t  wr[6];
    cal_vec_t cv[3];
    bit ok, rdone;
    int rtap;

    wr[0] = '{"wr_l2_100", 2, 100, 17, 1};
    wr[1] = '{"wr_l5_300", 5, 300, 17, 1};
    wr[2] = '{"wr_l0_511", 0, 511, 17, 1};
    wr[3] = '{"wr_l6_drop", 6, 7, 0, 0};
    wr[4] = '{"wr_l7_drop", 7, 9, 0, 0};
    wr[5] = '{"wr_l4_0", 4, 0, 17, 1};

    cv[0] = '{"cal_64_192", 64, 192, -1, -2, 1'b0, 128, 1'b1, 1'b1};
    cv[1] = '{"cal_tie", 16, 40, 200, 224, 1'b0, 28, 1'b1, 1'b0};
    cv[2] = '{"cal_silent", -1, -2, -1, -2, 1'b1, 25, 1'b0, 1'b0};

    for (int l = 0; l < NL; l++) mdl[l] = DEF;

    #2 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    check("rst_cfg_ready", cfg_ready, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("no_rdy_cfg_ready", cfg_ready, 0);
    dly_rdy = 1'b1;
    wait_ready(ok, 3);
    check("rdy_within_3", ok, 1);

    for (int i = 0; i < 6; i++)
      manual_write(wr[i].nm, wr[i].lane, wr[i].tap, wr[i].exp_lows, wr[i].exp_loads);

    for (int i = 0; i < 3; i++) begin
      fill_windows(cv[i].lo1, cv[i].hi1, cv[i].lo2, cv[i].hi2, cv[i].silent);
      run_cal(cv[i].nm, cv[i].exp_tap, cv[i].exp_done, cv[i].inject);
    end

    for (int r = 0; r < 4; r++) begin
      random_chan();
      ref_cal(rtap, rdone);
      run_cal($sformatf("cal_rand%0d", r), rtap, rdone, r == 1);
    end

    // Reset in the middle of a dwell: silent channel keeps step 0 dwelling ~100 cycles.
    fill_windows(-1, -2, -1, -2, 1'b1);
    wait_ready(ok, 50);
    chan_en = 1'b1; cal_start = 1'b1;
    @(negedge clock);
    cal_start = 1'b0;
    repeat (40) @(negedge clock);
    check("dwell_busy_before_rst", cal_busy, 1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clock);
    resetn = 1'b1; chan_en = 1'b0;
    @(negedge clock);
    check_reset_outputs("post_rst");
    for (int l = 0; l < NL; l++) mdl[l] = DEF;
    manual_write("wr_after_rst", 1, 77, 17, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rgmii_delay_tuner.md
Name: rgmii_delay_tuner

Overview:
Runtime controller for the RGMII I/O delay taps (IDELAYE3/ODELAYE3 in VAR_LOAD mode). It replaces compile-time fixed taps with per-lane loadable taps. It adds an auto-calibration sweep that scores each RX data tap using MAC good/bad-frame pulses, then settles on the centre of the widest passing window. It sits between the Ethernet wrapper's delay primitives and the MAC status outputs, all on the 125 MHz logic clock.

Parameters:
NUM_LANES, 6, delay lanes: 0-3 rxd, 4 rx_ctl, 5 tx_clk odelay
TAP_WIDTH, 9, CNTVALUEIN width
DEFAULT_TAP, 25, tap loaded into every lane after reset and after a failed calibration
TAP_STEP, 8, sweep increment; NUM_STEPS = 2**TAP_WIDTH / TAP_STEP
DWELL_FRAMES, 8, frames that must all be good for a step to pass
TIMEOUT_CYCLES, 1000000, cycles without a frame before the step is declared failed
VTC_GUARD, 8, cycles that EN_VTC is held low before and after a LOAD pulse

Ports:
clock  in  1  logic clock; the only clock
resetn  in  1  asynchronous, active-low reset
dly_rdy  in  1  IDELAYCTRL RDY, asynchronous; 2-flop synchronised internally
cfg_valid  in  1  manual tap write request
cfg_ready  out  1  high in IDLE only
cfg_lane  in  $clog2(NUM_LANES)  lane to write
cfg_tap  in  TAP_WIDTH  tap value to write
cal_start  in  1  1-cycle pulse that starts calibration (ignored unless IDLE)
frame_good  in  1  MAC rx_fifo_good_frame pulse
frame_bad  in  1  MAC rx_error_bad_fcs OR rx_fifo_bad_frame pulse
tap_value  out  NUM_LANES*TAP_WIDTH  CNTVALUEIN per lane, held between loads
tap_load  out  NUM_LANES  LOAD strobe per lane
en_vtc  out  NUM_LANES  EN_VTC per lane
cal_busy  out  1  calibration in progress
cal_done  out  1  sticky; set when calibration passes, cleared by cal_start
cal_fail  out  1  sticky; set when calibration fails, cleared by cal_start
cal_tap  out  TAP_WIDTH  chosen centre tap

Behaviour:
- Reset values: tap_value = DEFAULT_TAP on every lane; tap_load = 0; en_vtc = all 1; cal_busy/cal_done/cal_fail = 0; cal_tap = DEFAULT_TAP; state = WAIT_RDY.
- FSM states: WAIT_RDY, IDLE, PRE, LOAD, POST, DWELL, EVAL, FINISH.
- WAIT_RDY -> IDLE once the synchronised dly_rdy is 1. If dly_rdy drops in any state, abort to WAIT_RDY, clear cal_busy, keep current taps.
- Load sequence, lane mask M: PRE deasserts en_vtc[M] for VTC_GUARD cycles; LOAD drives tap_load[M] = 1 for exactly 1 cycle with tap_value already stable for ≥1 cycle; POST holds en_vtc[M] low for VTC_GUARD cycles, then reasserts it. Total cost = 2*VTC_GUARD+1 cycles.
- Manual write: cfg_valid && cfg_ready accepts the request. M = one-hot(cfg_lane); return to IDLE after POST. cfg_lane ≥ NUM_LANES is accepted and discarded, with no load.
- Calibration: cal_start in IDLE clears sticky flags, sets cal_busy, and sets step k = 0. For each step, tap = k*TAP_STEP is applied to lanes 0-4 (M = 5'b11111; lane 5 untouched), followed by DWELL.
- DWELL counts frames and stops at DWELL_FRAMES. frame_good and frame_bad in the same cycle count as one bad frame. Any bad frame, or TIMEOUT_CYCLES with no frame, fails the step immediately.
- EVAL: track the current run start and the best window (start, end). A strictly longer run replaces the best, so on ties the earliest window wins. Then k++. Go to FINISH after k = NUM_STEPS-1; no wrap.
- FINISH:
  - Window found: cal_tap = (start+end)>>1, computed in TAP_WIDTH+1 bits; load it into lanes 0-4; set cal_done.
  - No window: load DEFAULT_TAP; set cal_fail.
  - In both cases cal_busy clears when POST ends.
- Frame pulses outside DWELL are ignored. cal_start while busy is ignored.
- Mid-operation reset: all outputs return to their reset values asynchronously, including en_vtc = 1 and tap_load = 0.

Optional Feature:
RGMII_DELAY_MAP_EN: adds output cal_map [NUM_STEPS-1:0]. Bit k = pass result of step k, written in EVAL, cleared by cal_start and by reset. Without the macro the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package rgmii_delay_pkg: FSM state enum; lane index constants (LANE_RXD0..3, LANE_RXCTL, LANE_TXCLK); RX_LANE_MASK.
- Sub-module rgmii_delay_loader: the PRE/LOAD/POST EN_VTC sequencer with a mask input and a done output. It is shared by the manual-write and calibration paths.

Test Plan:
- Reset with dly_rdy = 0 -> all taps 25, en_vtc all 1, cfg_ready = 0. Raise dly_rdy -> cfg_ready = 1 within 3 cycles.
- Manual write lane 2 tap 100 -> en_vtc[2] low for 8 cycles, tap_load[2] high for 1 cycle with tap_value lane 2 = 100, en_vtc[2] high after 8 more cycles; other lanes unchanged.
- Calibration with frames all good for taps 64..192 and bad elsewhere -> cal_tap = 128, lanes 0-4 = 128, lane 5 = 25, cal_done = 1.
- Two passing windows 16..40 and 200..224 (equal length) -> cal_tap = 28.
- No frames at all (TIMEOUT_CYCLES = 100) -> every step fails, taps = 25, cal_fail = 1.
- Assert resetn low during DWELL, then release -> all outputs at reset values. cal_start during calibration is ignored, and the sweep completes normally.
